// File: rtl/fpu_arb_pkg.sv
// Shared helpers for the FPU share arbiter: tag index width and credit width.
package fpu_arb_pkg;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/fpu_arb_rr_sel.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping around.
module fpu_arb_rr_sel #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);

  function automatic int wrap(input int p, input int i);
    return (p + i >= N) ? p + i - N : p + i;
  endfunction

  // Scan farthest offset first so the nearest request is written last.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[wrap(int'(ptr), i)])
        idx = W'(wrap(int'(ptr), i));
    end
  end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one APU/FPU among NB_CORES cores with round-robin arbitration.
// Define FPU_ARB_CREDIT_EN to cap per-core in-flight requests.
module fpu_share_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NB_CORES        = 4,
  parameter int CORE_ID_WIDTH   = 9,
  parameter int IDX_WIDTH       = idx_width(NB_CORES),
  parameter int NB_ARGS         = 3,
  parameter int DATA_WIDTH      = 32,
  parameter int OPCODE_WIDTH    = 6,
  parameter int FLAGS_IN_WIDTH  = 15,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [NB_CORES-1:0] core_req_i,
  output logic [NB_CORES-1:0] core_gnt_o,
  input  logic [NB_CORES-1:0][CORE_ID_WIDTH-1:0] core_ID_i,
  input  logic [NB_CORES-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0] core_operands_i,
  input  logic [NB_CORES-1:0][OPCODE_WIDTH-1:0] core_op_i,
  input  logic [NB_CORES-1:0][FLAGS_IN_WIDTH-1:0] core_flags_i,
  output logic [NB_CORES-1:0] core_rvalid_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0] core_rflags_o,
  output logic [CORE_ID_WIDTH-1:0] core_rID_o,
  output logic apu_req_o,
  input  logic apu_gnt_i,
  output logic [IDX_WIDTH+CORE_ID_WIDTH-1:0] apu_ID_o,
  output logic [NB_ARGS-1:0][DATA_WIDTH-1:0] apu_operands_o,
  output logic [OPCODE_WIDTH-1:0] apu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0] apu_flags_o,
  input  logic apu_rvalid_i,
  input  logic [DATA_WIDTH-1:0] apu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0] apu_rflags_i,
  input  logic [IDX_WIDTH+CORE_ID_WIDTH-1:0] apu_rID_i
);

  localparam int TW = IDX_WIDTH + CORE_ID_WIDTH;

  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] win;
  logic [IDX_WIDTH-1:0] rsp_idx;
  logic [NB_CORES-1:0]  elig;
  logic [NB_CORES-1:0]  rsp_hit;
  logic                 win_vld;
  logic                 xfer;

  fpu_arb_rr_sel #(
    .N (NB_CORES),
    .W (IDX_WIDTH)
  ) u_sel (
    .req   (elig),
    .ptr   (rr_ptr),
    .idx   (win),
    .valid (win_vld)
  );

  assign apu_req_o = win_vld & ~rst;
  assign xfer      = apu_req_o & apu_gnt_i;

  always_comb begin
    core_gnt_o = '0;
    if (xfer)
      core_gnt_o[win] = 1'b1;
  end

  assign apu_ID_o       = {win, core_ID_i[win]};
  assign apu_operands_o = core_operands_i[win];
  assign apu_op_o       = core_op_i[win];
  assign apu_flags_o    = core_flags_i[win];

  // Explicit wrap so non-power-of-two core counts work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (xfer)
      rr_ptr <= (win == IDX_WIDTH'(NB_CORES - 1)) ? '0 : win + 1'b1;
  end

  assign rsp_idx = apu_rID_i[TW-1 -: IDX_WIDTH];

  always_comb begin
    rsp_hit = '0;
    for (int k = 0; k < NB_CORES; k++)
      rsp_hit[k] = apu_rvalid_i & (rsp_idx == IDX_WIDTH'(k));
  end

  assign core_rvalid_o = rst ? '0 : rsp_hit;
  assign core_rdata_o  = apu_rdata_i;
  assign core_rflags_o = apu_rflags_i;
  assign core_rID_o    = apu_rID_i[CORE_ID_WIDTH-1:0];

`ifdef FPU_ARB_CREDIT_EN
  localparam int CW = cnt_width(MAX_OUTSTANDING);

  logic [NB_CORES-1:0][CW-1:0] cnt;
  logic [NB_CORES-1:0]         take;

  always_comb begin
    elig = '0;
    take = '0;
    for (int k = 0; k < NB_CORES; k++) begin
      elig[k] = core_req_i[k] & (cnt[k] < CW'(MAX_OUTSTANDING));
      take[k] = xfer & (win == IDX_WIDTH'(k));
    end
  end

  // Issue and retire in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int k = 0; k < NB_CORES; k++) begin
        unique case ({take[k], rsp_hit[k]})
          2'b10: cnt[k] <= cnt[k] + 1'b1;
          2'b01: if (cnt[k] != '0) cnt[k] <= cnt[k] - 1'b1;
          default: ;
        endcase
      end
    end
  end
`else
  assign elig = core_req_i;
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed self-checking bench for fpu_share_arbiter.
module tb_fpu_share_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic [3:0]             req;
  logic [3:0]             gnt;
  logic [3:0][8:0]        cid;
  logic [3:0][2:0][31:0]  opnd;
  logic [3:0][5:0]        op;
  logic [3:0][14:0]       flg;
  logic [3:0]             rvld;
  logic [31:0]            rdata;
  logic [4:0]             rflags;
  logic [8:0]             rid;
  logic                   a_req;
  logic                   a_gnt;
  logic [10:0]            a_id;
  logic [2:0][31:0]       a_opnd;
  logic [5:0]             a_op;
  logic [14:0]            a_flg;
  logic                   a_rvalid;
  logic [31:0]            a_rdata;
  logic [4:0]             a_rflags;
  logic [10:0]            a_rid;

  logic [2:0]             s_req;
  logic [2:0]             s_gnt;
  logic [2:0][8:0]        s_cid;
  logic [2:0][2:0][31:0]  s_opnd;
  logic [2:0][5:0]        s_op;
  logic [2:0][14:0]       s_flg;
  logic [2:0]             s_rvld;
  logic [31:0]            s_rdata;
  logic [4:0]             s_rflags;
  logic [8:0]             s_rid;
  logic                   s_areq;
  logic [10:0]            s_aid;
  logic [2:0][31:0]       s_aopnd;
  logic [5:0]             s_aop;
  logic [14:0]            s_aflg;
  logic                   s_arvalid;
  logic [10:0]            s_arid;

  int nvec = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fpu_share_arbiter #(
    .NB_CORES        (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .core_req_i      (req),
    .core_gnt_o      (gnt),
    .core_ID_i       (cid),
    .core_operands_i (opnd),
    .core_op_i       (op),
    .core_flags_i    (flg),
    .core_rvalid_o   (rvld),
    .core_rdata_o    (rdata),
    .core_rflags_o   (rflags),
    .core_rID_o      (rid),
    .apu_req_o       (a_req),
    .apu_gnt_i       (a_gnt),
    .apu_ID_o        (a_id),
    .apu_operands_o  (a_opnd),
    .apu_op_o        (a_op),
    .apu_flags_o     (a_flg),
    .apu_rvalid_i    (a_rvalid),
    .apu_rdata_i     (a_rdata),
    .apu_rflags_i    (a_rflags),
    .apu_rID_i       (a_rid)
  );

  fpu_share_arbiter #(
    .NB_CORES (3)
  ) dut3 (
    .clk             (clk),
    .rst             (rst),
    .core_req_i      (s_req),
    .core_gnt_o      (s_gnt),
    .core_ID_i       (s_cid),
    .core_operands_i (s_opnd),
    .core_op_i       (s_op),
    .core_flags_i    (s_flg),
    .core_rvalid_o   (s_rvld),
    .core_rdata_o    (s_rdata),
    .core_rflags_o   (s_rflags),
    .core_rID_o      (s_rid),
    .apu_req_o       (s_areq),
    .apu_gnt_i       (1'b0),
    .apu_ID_o        (s_aid),
    .apu_operands_o  (s_aopnd),
    .apu_op_o        (s_aop),
    .apu_flags_o     (s_aflg),
    .apu_rvalid_i    (s_arvalid),
    .apu_rdata_i     (32'h0),
    .apu_rflags_i    (5'h0),
    .apu_rID_i       (s_arid)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cid[k] = 9'(9'h010 + k);
      op[k]  = 6'(k + 1);
      flg[k] = 15'(15'h100 + k);
      for (int j = 0; j < 3; j++)
        opnd[k][j] = 32'hA000_0000 | 32'(k << 8) | 32'(j);
    end
    s_req = '0; s_cid = '0; s_opnd = '0; s_op = '0; s_flg = '0;
    s_arvalid = 1'b0; s_arid = '0;
    req = 4'hf;
    a_gnt = 1'b1;
    a_rvalid = 1'b1;
    a_rid = 11'h000;
    a_rdata = '0;
    a_rflags = '0;

    #1;
    chk("reset_req", 64'(a_req), 64'd0);
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_rvalid", 64'(rvld), 64'd0);

    @(negedge clk);
    rst = 1'b0; req = '0; a_rvalid = 1'b0;
    #1;
    chk("idle_req", 64'(a_req), 64'd0);

    // Single requester: core 2
    @(negedge clk);
    req = 4'b0100; cid[2] = 9'h1A5;
    #1;
    chk("single_id", 64'(a_id), 64'h5A5);
    chk("single_gnt", 64'(gnt), 64'b0100);
    chk("single_op", 64'(a_op), 64'd3);
    chk("single_opnd", 64'(a_opnd[1]), 64'hA000_0201);
    chk("single_flags", 64'(a_flg), 64'h102);

    // Pointer now 3: cores 0 and 3 request -> core 3
    @(negedge clk);
    req = 4'b1001;
    #1;
    chk("ptr3_gnt", 64'(gnt), 64'b1000);
    chk("ptr3_idx", 64'(a_id[10:9]), 64'd3);

    pulse_rst();

    // All four request continuously
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req = 4'hf; a_gnt = 1'b1;
      #1;
      chk($sformatf("rr_gnt%0d", i), 64'(gnt), 64'(1 << (i % 4)));
    end

    pulse_rst();

    // FPU stalls with cores 1 and 3 requesting
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req = 4'b1010; a_gnt = 1'b0;
      #1;
      chk($sformatf("stall_gnt%0d", i), 64'(gnt), 64'd0);
      chk($sformatf("stall_req%0d", i), 64'(a_req), 64'd1);
      chk($sformatf("stall_idx%0d", i), 64'(a_id[10:9]), 64'd1);
    end
    @(negedge clk);
    a_gnt = 1'b1;
    #1;
    chk("unstall_gnt", 64'(gnt), 64'b0010);
    @(negedge clk);
    #1;
    chk("unstall_next", 64'(gnt), 64'b1000);

    // Response routing
    @(negedge clk);
    req = '0; a_rvalid = 1'b1; a_rid = 11'h644;
    a_rdata = 32'hDEAD_BEEF; a_rflags = 5'h11;
    s_arvalid = 1'b1; s_arid = 11'h644;
    #1;
    chk("rsp_valid3", 64'(rvld), 64'b1000);
    chk("rsp_id", 64'(rid), 64'h044);
    chk("rsp_data", 64'(rdata), 64'hDEAD_BEEF);
    chk("rsp_flags", 64'(rflags), 64'h11);
    chk("rsp_oob", 64'(s_rvld), 64'd0);
    a_rid = 11'h007; s_arid = 11'h444;
    #1;
    chk("rsp_valid0", 64'(rvld), 64'b0001);
    chk("rsp_n3_idx2", 64'(s_rvld), 64'b100);
    @(negedge clk);
    a_rvalid = 1'b0; s_arvalid = 1'b0;
    #1;
    chk("rsp_none", 64'(rvld), 64'd0);

    // Reset mid-burst, released before any clock edge
    @(negedge clk);
    req = 4'hf; a_gnt = 1'b1;
    #1;
    chk("burst_gnt", 64'(gnt), 64'b0001);
    @(negedge clk);
    req = 4'b0101; a_rvalid = 1'b1; a_rid = 11'h644;
    rst = 1'b1;
    #1;
    chk("midrst_req", 64'(a_req), 64'd0);
    chk("midrst_gnt", 64'(gnt), 64'd0);
    chk("midrst_rvalid", 64'(rvld), 64'd0);
    #1;
    rst = 1'b0; a_rvalid = 1'b0;
    #1;
    chk("postrst_gnt", 64'(gnt), 64'b0001);

`ifdef FPU_ARB_CREDIT_EN
    pulse_rst();
    @(negedge clk);
    req = 4'b0001; a_gnt = 1'b1;
    #1;
    chk("cred_gnt1", 64'(gnt), 64'b0001);
    @(negedge clk);
    #1;
    chk("cred_gnt2", 64'(gnt), 64'b0001);
    @(negedge clk);
    #1;
    chk("cred_mask", 64'(a_req), 64'd0);
    @(negedge clk);
    a_rvalid = 1'b1; a_rid = 11'h000;
    #1;
    chk("cred_mask_rsp", 64'(a_req), 64'd0);
    @(negedge clk);
    #1;
    chk("cred_both", 64'(gnt), 64'b0001);
    @(negedge clk);
    a_rvalid = 1'b0;
    #1;
    chk("cred_hold", 64'(gnt), 64'b0001);
    @(negedge clk);
    #1;
    chk("cred_full", 64'(a_req), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

endmodule
